// File: rtl/div_rem_unit_pkg.sv
// Shared RV32M divide/remainder definitions: funct encodings and divider FSM states.
package div_rem_unit_pkg;

    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StDone = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_rem_unit_if.sv
// Request/response bundle between the execute stage and the divide/remainder unit.
interface div_rem_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            flush_i;
    logic            busy_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, funct3_i, rs1_i, rs2_i, flush_i,
        input  busy_o, valid_o, result_o
    );

    modport slave (
        input  start_i, funct3_i, rs1_i, rs2_i, flush_i,
        output busy_o, valid_o, result_o
    );

endinterface

// File: rtl/div_rem_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring division, one quotient bit
// per clock, with divide-by-zero and signed overflow resolved without iterating.
module div_rem_unit
    import div_rem_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input logic           clk,
    input logic           rst_n,
    div_rem_unit_if.slave bus
);

    localparam int unsigned CntW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            op_rem_q, op_rem_d;
    logic            op_sgn_q, op_sgn_d;
    logic            neg_q_q, neg_q_d;
    logic            neg_r_q, neg_r_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            in_sgn;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   trial;
    logic            ge;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quo_nx;
    logic [XLEN-1:0] final_val;

    always_comb begin
        in_sgn = ~bus.funct3_i[0];

        // Shifted remainder can reach XLEN+1 bits; a set MSB always means it exceeds the divisor.
        rem_sh = {rem_q, quo_q[XLEN-1]};
        trial  = rem_sh - {1'b0, dvs_q};
        ge     = rem_q[XLEN-1] | ~trial[XLEN];
        rem_nx = ge ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_nx = {quo_q[XLEN-2:0], ge};

        if (op_rem_q) begin
            final_val = (neg_r_q && op_sgn_q) ? -rem_nx : rem_nx;
        end else begin
            final_val = (neg_q_q && op_sgn_q) ? -quo_nx : quo_nx;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        op_rem_d = op_rem_q;
        op_sgn_d = op_sgn_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        result_d = result_q;

        if (bus.flush_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start_i && bus.funct3_i[2]) begin
                        op_rem_d = bus.funct3_i[1];
                        op_sgn_d = in_sgn;
                        neg_q_d  = bus.rs1_i[XLEN-1] ^ bus.rs2_i[XLEN-1];
                        neg_r_d  = bus.rs1_i[XLEN-1];
                        rem_d    = '0;
                        quo_d    = (in_sgn && bus.rs1_i[XLEN-1]) ? -bus.rs1_i : bus.rs1_i;
                        dvs_d    = (in_sgn && bus.rs2_i[XLEN-1]) ? -bus.rs2_i : bus.rs2_i;
                        if (bus.rs2_i == '0) begin
                            result_d = bus.funct3_i[1] ? bus.rs1_i : '1;
                            state_d  = StDone;
                        end else if (in_sgn && bus.rs1_i == MinNeg && bus.rs2_i == '1) begin
                            result_d = bus.funct3_i[1] ? '0 : MinNeg;
                            state_d  = StDone;
                        end else begin
                            cnt_d   = CntW'(XLEN - 1);
                            state_d = StCalc;
                        end
                    end
                end
                StCalc: begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == '0) begin
                        result_d = final_val;
                        state_d  = StDone;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            op_rem_q <= 1'b0;
            op_sgn_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            op_rem_q <= op_rem_d;
            op_sgn_q <= op_sgn_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            result_q <= result_d;
        end
    end

    assign bus.busy_o   = (state_q != StIdle);
    assign bus.valid_o  = (state_q == StDone);
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_div_rem_unit.sv
// Directed and model-checked bench for the divide/remainder unit.
module tb_div_rem_unit;
    import div_rem_unit_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    div_rem_unit_if #(.XLEN(32)) bus ();

    div_rem_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Golden model from native SV arithmetic; special cases handled explicitly.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return f3[1] ? 32'd0 : 32'h8000_0000;
        case (f3)
            FUNCT3_DIV:  return sa / sb;
            FUNCT3_DIVU: return a / b;
            FUNCT3_REM:  return sa % sb;
            default:     return a % b;
        endcase
    endfunction

    // Starts at a negedge; poke injects a busy-time start with other operands at cycle 5.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input bit poke);
        int lat;
        int busy_cnt;
        lat      = 0;
        busy_cnt = 0;
        @(negedge clk);
        bus.start_i  = 1'b1;
        bus.funct3_i = f3;
        bus.rs1_i    = a;
        bus.rs2_i    = b;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.busy_o) busy_cnt++;
            if (poke && c == 5) begin
                bus.start_i  = 1'b1;
                bus.funct3_i = FUNCT3_DIVU;
                bus.rs1_i    = 32'd1;
                bus.rs2_i    = 32'd1;
            end else begin
                bus.start_i = 1'b0;
            end
            if (bus.valid_o) begin
                lat = c;
                break;
            end
        end
        bus.start_i = 1'b0;
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, bus.result_o, exp_res);
        check({tag, " busy cycles"}, busy_cnt, exp_lat);
    endtask

    initial begin
        int lat;
        logic [31:0] held;
        logic [31:0] a, b, e;
        logic [2:0]  f3;
        bit          saw_valid;

        n_checks     = 0;
        n_errors     = 0;
        bus.start_i  = 1'b0;
        bus.funct3_i = 3'b000;
        bus.rs1_i    = '0;
        bus.rs2_i    = '0;
        bus.flush_i  = 1'b0;
        rst_n        = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", bus.busy_o, 0);
        check("reset valid", bus.valid_o, 0);
        check("reset result", bus.result_o, 0);
        rst_n = 1'b1;

        run_op("div 20/-3", FUNCT3_DIV, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 33, 0);
        run_op("rem -20/3", FUNCT3_REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33, 0);
        run_op("remu ffffffff/2", FUNCT3_REMU, 32'hFFFF_FFFF, 32'd2, 32'h1, 33, 0);
        run_op("divu ffffffff/2", FUNCT3_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 33, 0);
        run_op("divu big", FUNCT3_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h1, 33, 0);
        run_op("remu big", FUNCT3_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33, 0);
        run_op("rem 100/-7", FUNCT3_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, 33, 0);
        run_op("div -100/7", FUNCT3_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, 0);
        run_op("divu 7/0", FUNCT3_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("rem 7/0", FUNCT3_REM, 32'd7, 32'd0, 32'd7, 1, 0);
        run_op("div -5/0", FUNCT3_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("div ovf", FUNCT3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("rem ovf", FUNCT3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
        run_op("busy poke", FUNCT3_DIV, 32'd100, 32'd7, 32'd14, 33, 1);

        // Flush in cycle 10 of DIV 100/7 after leaving a distinct result behind.
        run_op("pre-flush", FUNCT3_REMU, 32'd100, 32'd7, 32'd2, 33, 0);
        held = 32'd2;
        @(negedge clk);
        bus.start_i  = 1'b1;
        bus.funct3_i = FUNCT3_DIV;
        bus.rs1_i    = 32'd100;
        bus.rs2_i    = 32'd7;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (10) @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1 bus.flush_i = 1'b0;
        @(negedge clk);
        check("flush busy", bus.busy_o, 0);
        check("flush valid", bus.valid_o, 0);
        check("flush result", bus.result_o, held);
        saw_valid = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.valid_o) saw_valid = 1'b1;
        end
        check("flush no pulse", saw_valid, 0);
        run_op("restart", FUNCT3_DIV, 32'd100, 32'd7, 32'd14, 33, 0);

        // Flush and start together: request dropped.
        @(negedge clk);
        bus.start_i  = 1'b1;
        bus.flush_i  = 1'b1;
        bus.funct3_i = FUNCT3_DIV;
        @(posedge clk);
        #1 begin
            bus.start_i = 1'b0;
            bus.flush_i = 1'b0;
        end
        @(negedge clk);
        check("flush+start busy", bus.busy_o, 0);

        // funct3 without bit 2 is not a divide.
        bus.start_i  = 1'b1;
        bus.funct3_i = 3'b000;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        @(negedge clk);
        check("f3 000 busy", bus.busy_o, 0);
        check("f3 000 valid", bus.valid_o, 0);
        check("f3 000 result", bus.result_o, 32'd14);

        // Asynchronous reset in the middle of CALC.
        bus.start_i  = 1'b1;
        bus.funct3_i = FUNCT3_DIVU;
        bus.rs1_i    = 32'd1000;
        bus.rs2_i    = 32'd3;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (5) @(negedge clk);
        check("pre-reset busy", bus.busy_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst busy", bus.busy_o, 0);
        check("async rst valid", bus.valid_o, 0);
        check("async rst result", bus.result_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised compare against the model.
        for (int i = 0; i < 400; i++) begin
            f3 = 3'b100 | 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) b = 32'd0;
            if ($urandom_range(0, 15) == 0) b = 32'hFFFF_FFFF;
            if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
            e   = model(f3, a, b);
            lat = (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
            run_op("random", f3, a, b, e, lat, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
